numerical_differentiator: RTL
=============================

Name: numerical_differentiator

Overview:
- Inverse companion to the trajectory integrator: recovers rate of change (e.g. velocity from height, acceleration from velocity) from a sampled fixed-point signal.
- Computes the first difference per accepted sample, smooths it with a 2^WIN_LOG2-deep moving-average window, and scales the result by GAIN (inverse sample period in the ISF=1000 fixed-point convention).
- Sits downstream of the velocity/height generators and feeds gimbal and attitude logic.

Parameters:
- N, 64, data width of input and output.
- WIN_LOG2, 2, log2 of the moving-average window depth (window = 4).
- GAIN, 1000, unsigned integer scale applied to the averaged difference.

Ports:
- clk  in  1  system clock.
- resetb  in  1  reset; synchronous, active-high (1 = reset).
- signal_input  in  N  unsigned sample value.
- sample_valid  in  1  qualifies signal_input for one cycle.
- start_differentiation  in  1  level enable; 1 = run, 0 = stop.
- derivative_result  out  N  signed, scaled, smoothed derivative.
- result_valid  out  1  one-cycle pulse when derivative_result updates.
- saturated  out  1  sticky flag: a result was clipped.

Behaviour:
- Reset (resetb=1 at posedge): state IDLE; derivative_result=0, result_valid=0, saturated=0; prev sample, ring buffer, running sum and fill count cleared. Reset overrides every other input, including mid-operation.
- IDLE: samples are ignored. start_differentiation=1 moves to PRIME at the next edge and clears prev, ring, sum, fill count and saturated.
- PRIME: the first sample_valid stores prev=signal_input and moves to FILL. No result is produced.
- FILL/RUN per accepted sample:
  - diff = signal_input - prev, signed N+1 bits.
  - Push diff into the ring; sum = sum + diff - oldest, where oldest is 0 until the ring is full.
  - prev = signal_input.
  - Sum width is N+1+WIN_LOG2; it never overflows.
- FILL counts pushed diffs. After the 2^WIN_LOG2-th diff, go to RUN and emit the first result.
- Result timing:
  - Emitted on the cycle after the accepting edge; latency is 1 clock from sample_valid to result_valid.
  - In RUN, every accepted sample produces exactly one result_valid pulse.
  - Back-to-back sample_valid every cycle is supported.
- Arithmetic:
  - avg = sum >>> WIN_LOG2 (arithmetic shift, rounds toward -inf).
  - prod = avg * GAIN at full width.
  - Saturate prod to the signed N range [-2^(N-1), 2^(N-1)-1]. On clip, set saturated=1; it holds until restart or reset.
- derivative_result holds its last value between pulses and while IDLE.
- start_differentiation=0 in any non-IDLE state returns to IDLE at the next edge. A sample_valid in that same cycle is discarded. A later restart re-primes from scratch.
- sample_valid while resetb=1 or in IDLE has no effect.

Decomposition:
- Shared package numerical_pkg holds:
  - N default and ISF=1000 scale constant.
  - state encoding {IDLE, PRIME, FILL, RUN}.
  - saturation helper function, shared with the integrator.
- One sub-module, diff_window: ring buffer plus running sum with push, clear, full flag and sum output.
- The top holds the FSM, prev register, scaling and saturation.

Test Plan:
- Ramp: start=1; samples 0,10,20,30,40 every 3 cycles (GAIN=1000, WIN_LOG2=2) -> first result_valid 1 clk after the 5th sample, derivative_result=10000; each further +10 sample gives 10000 again.
- Constant input 5000 x8 -> results after the 5th sample all 0; saturated=0.
- Falling ramp 1000,990,...,950 -> derivative_result=-10000 (two's complement).
- Step: 0,0,0,0,0,400,400,400,400,400 -> the result after sample 400 is 100000, stays 100000 for three more samples, then 0.
- Saturation (N=16): 0 x5, then 65535 -> result 32767 and saturated=1; saturated stays 1 for following results.
- Control: resetb=1 mid-RUN -> next cycle all outputs 0, state IDLE. Dropping start with a coincident sample_valid -> no pulse. Re-asserting start -> needs 5 new samples before result_valid.

Source files
------------

// File: rtl/numerical_pkg.sv
// Shared constants, FSM encoding and saturation helper for the fixed-point
// differentiator/integrator pair.
package numerical_pkg;

  localparam int N_DEFAULT = 64;
  localparam int ISF       = 1000;
  // Wide enough for (N+1+WIN_LOG2)-bit sums times a 32-bit gain at N=64.
  localparam int SAT_W     = 128;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    FILL,
    RUN
  } state_e;

  function automatic logic signed [SAT_W-1:0] sat_limit(
    input logic signed [SAT_W-1:0] val,
    input int unsigned             width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
    lo = ~hi;
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/numerical_differentiator_if.sv
// Sample/result bundle between the signal source, the differentiator and
// its consumer.
interface numerical_differentiator_if
  import numerical_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  logic [N-1:0] signal_input;
  logic         sample_valid;
  logic         start_differentiation;
  logic [N-1:0] derivative_result;
  logic         result_valid;
  logic         saturated;

  modport master (
    output signal_input,
    output sample_valid,
    output start_differentiation,
    input  derivative_result,
    input  result_valid,
    input  saturated
  );

  modport slave (
    input  signal_input,
    input  sample_valid,
    input  start_differentiation,
    output derivative_result,
    output result_valid,
    output saturated
  );
endinterface

// File: rtl/diff_window.sv
// Moving-sum window over the last 2^WIN_LOG2 signed differences; the sum
// output already includes the diff being pushed this cycle.
module diff_window #(
  parameter int DW       = 65,
  parameter int WIN_LOG2 = 2
) (
  input  logic                             clk,
  input  logic                             resetb,
  input  logic                             clear_i,
  input  logic                             push_i,
  input  logic signed [DW-1:0]             diff_i,
  output logic                             full_o,
  output logic                             almost_full_o,
  output logic signed [DW+WIN_LOG2-1:0]    sum_next_o
);
  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SUM_W = DW + WIN_LOG2;

  logic signed [DW-1:0]    ring_q [DEPTH];
  logic [WIN_LOG2-1:0]     wr_ptr_q;
  logic [WIN_LOG2:0]       cnt_q;
  logic signed [SUM_W-1:0] sum_q;

  assign full_o        = (cnt_q == (WIN_LOG2 + 1)'(DEPTH));
  assign almost_full_o = (cnt_q == (WIN_LOG2 + 1)'(DEPTH - 1));

  // Slots start at zero, so the evicted entry reads as 0 until the ring wraps.
  assign sum_next_o = push_i ? (sum_q + SUM_W'(diff_i) - SUM_W'(ring_q[wr_ptr_q])) : sum_q;

  always_ff @(posedge clk) begin
    if (resetb || clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
    end else if (push_i) begin
      ring_q[wr_ptr_q] <= diff_i;
      wr_ptr_q         <= wr_ptr_q + 1'b1;
      if (!full_o) begin
        cnt_q <= cnt_q + 1'b1;
      end
      sum_q <= sum_next_o;
    end
  end
endmodule

// File: rtl/numerical_differentiator.sv
// Smoothed, scaled first difference of a sampled unsigned signal, with a
// sticky flag for results clipped to the signed N-bit range.
module numerical_differentiator
  import numerical_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int WIN_LOG2 = 2,
  parameter int GAIN     = ISF
) (
  input  logic                       clk,
  input  logic                       resetb,
  numerical_differentiator_if.slave  bus
);
  localparam int DW    = N + 1;
  localparam int SUM_W = DW + WIN_LOG2;

  state_e                  state_q, state_d;
  logic [N-1:0]            prev_q, prev_d;
  logic [N-1:0]            result_q, result_d;
  logic                    valid_q, valid_d;
  logic                    sat_q, sat_d;

  logic                    push;
  logic                    clear;
  logic                    full;
  logic                    almost_full;
  logic signed [DW-1:0]    diff;
  logic signed [SUM_W-1:0] sum_next;
  logic signed [SUM_W-1:0] avg;
  logic signed [SAT_W-1:0] prod;
  logic signed [SAT_W-1:0] clipped_val;

  assign diff        = $signed({1'b0, bus.signal_input}) - $signed({1'b0, prev_q});
  assign avg         = sum_next >>> WIN_LOG2;
  assign prod        = SAT_W'(avg) * SAT_W'(GAIN);
  assign clipped_val = sat_limit(prod, N);

  diff_window #(
    .DW       (DW),
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .clk           (clk),
    .resetb        (resetb),
    .clear_i       (clear),
    .push_i        (push),
    .diff_i        (diff),
    .full_o        (full),
    .almost_full_o (almost_full),
    .sum_next_o    (sum_next)
  );

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    result_d = result_q;
    valid_d  = 1'b0;
    sat_d    = sat_q;
    push     = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_differentiation) begin
          state_d = PRIME;
          clear   = 1'b1;
          prev_d  = '0;
          sat_d   = 1'b0;
        end
      end
      PRIME: begin
        if (!bus.start_differentiation) begin
          state_d = IDLE;
        end else if (bus.sample_valid) begin
          prev_d  = bus.signal_input;
          state_d = FILL;
        end
      end
      FILL, RUN: begin
        if (!bus.start_differentiation) begin
          state_d = IDLE;
        end else if (bus.sample_valid) begin
          push   = 1'b1;
          prev_d = bus.signal_input;
          // The push that completes the window produces the first result.
          if (full || almost_full) begin
            state_d  = RUN;
            valid_d  = 1'b1;
            result_d = N'(clipped_val);
            sat_d    = sat_q | (clipped_val != prod);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
    end
  end

  assign bus.derivative_result = result_q;
  assign bus.result_valid      = valid_q;
  assign bus.saturated         = sat_q;
endmodule
